id_stage: RTL and testbench

//  Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch.

---
 rtl/id_stage_pkg.sv | 67 ++++++
 rtl/id_stage_reg_file.sv | 49 ++++
 rtl/id_stage.sv | 165 ++++++++++++++++
 tb/tb_id_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// id_stage_pkg
//   Shared constants and helpers for the MIPS instruction-decode stage:
//   datapath sizing, opcode/funct encodings, the branch-kind classifier,
//   and the unpacked view of an instruction word.
package id_stage_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int NREG_DEF   = 32;

   // Opcode / funct encodings used by decode and branch resolution
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] FN_JR    = 6'h08;

   typedef enum logic [2:0] {
      BR_NONE,
      BR_BEQ,
      BR_BNE,
      BR_JUMP,   // j and jal share the pseudo-direct target form
      BR_JR
   } br_kind_e;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
   } ins_fields_t;

   function automatic ins_fields_t split_ins(input logic [31:0] ins);
      ins_fields_t f;
      f.op    = ins[31:26];
      f.rs    = ins[25:21];
      f.rt    = ins[20:16];
      f.rd    = ins[15:11];
      f.shamt = ins[10:6];
      f.funct = ins[5:0];
      return f;
   endfunction

   function automatic br_kind_e classify_br(input logic [5:0] op, input logic [5:0] funct);
      br_kind_e k;
      k = BR_NONE;
      case (op)
         OP_BEQ:          k = BR_BEQ;
         OP_BNE:          k = BR_BNE;
         OP_J, OP_JAL:    k = BR_JUMP;
         OP_RTYPE:        if (funct == FN_JR) k = BR_JR;
         default:         k = BR_NONE;
      endcase
      return k;
   endfunction

   // logical immediates are zero-extended, everything else sign-extended
   function automatic logic is_zext_op(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// id_stage_reg_file
//   NREG x DATA_W register file, 2 combinational read ports, 1 write port.
//   Register 0 is hard-wired to zero. A write in the same cycle as a read of
//   the same register is forwarded to the reader (write-first bypass).
//   Synchronous active-high reset clears every entry.
// Ports
//   clk, rst        clock / sync reset
//   we, wa, wd      write enable, index, data
//   ra0, ra1        read indices
//   rd0, rd1        read data
module id_stage_reg_file
   import id_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREG   = NREG_DEF,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [AW-1:0]     ra0,
   input  logic [AW-1:0]     ra1,
   output logic [DATA_W-1:0] rd0,
   output logic [DATA_W-1:0] rd1
);

   logic [DATA_W-1:0] mem [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we && (wa != '0)) begin
         mem[wa] <= wd;
      end
   end

   always_comb begin
      rd0 = '0;
      if (ra0 != '0) rd0 = (we && (wa == ra0)) ? wd : mem[ra0];
   end

   always_comb begin
      rd1 = '0;
      if (ra1 != '0) rd1 = (we && (wa == ra1)) ? wd : mem[ra1];
   end

endmodule

// File: rtl/id_stage.sv
// id_stage
//   Instruction-decode stage of the 5-stage MIPS pipeline. Holds the IF/ID
//   register and the register file, decodes fields, resolves beq/bne/j/jal/jr
//   and detects load-use / branch-operand hazards.
// Ports
//   CLK, RST                 clock / sync active-high reset
//   Ins, nextPC              fetched instruction and its PC+4
//   WB_WE, WB_Rd, WB_Data    register write-back
//   EX_MemRd, EX_RegWr, EX_Dst  state of the instruction currently in EX
//   Stall                    hold PC and IF/ID (combinational)
//   BrTaken, BrTarget        fetch redirect (combinational)
//   ID_Valid                 0 = bubble into EX
//   Op, Funct, Rs, Rt, Rd, Shamt, Imm   decoded fields
//   RsVal, RtVal             operand values (write-back bypassed)
//   PC4                      latched PC+4, used for the jal link
module id_stage
   import id_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREG   = NREG_DEF,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [31:0]       Ins,
   input  logic [DATA_W-1:0] nextPC,
   input  logic              WB_WE,
   input  logic [AW-1:0]     WB_Rd,
   input  logic [DATA_W-1:0] WB_Data,
   input  logic              EX_MemRd,
   input  logic              EX_RegWr,
   input  logic [AW-1:0]     EX_Dst,
   output logic              Stall,
   output logic              BrTaken,
   output logic [DATA_W-1:0] BrTarget,
   output logic              ID_Valid,
   output logic [5:0]        Op,
   output logic [5:0]        Funct,
   output logic [AW-1:0]     Rs,
   output logic [AW-1:0]     Rt,
   output logic [AW-1:0]     Rd,
   output logic [4:0]        Shamt,
   output logic [DATA_W-1:0] Imm,
   output logic [DATA_W-1:0] RsVal,
   output logic [DATA_W-1:0] RtVal,
   output logic [DATA_W-1:0] PC4
);

   // IF/ID pipeline register
   logic [31:0]       ir;
   logic [DATA_W-1:0] pc4;
   logic              vld;

   ins_fields_t       f;
   br_kind_e          kind;
   logic [DATA_W-1:0] rs_val, rt_val;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] br_off;
   logic [DATA_W-1:0] target;
   logic              cond;
   logic              load_use, br_src_hit, br_hz;
   logic              stall, taken;

   always_ff @(posedge CLK) begin
      if (RST) begin
         ir  <= '0;
         pc4 <= '0;
         vld <= 1'b0;
      end else if (taken) begin
         // no delay slot: the instruction fetched behind a taken branch dies
         ir  <= '0;
         vld <= 1'b0;
      end else if (!stall) begin
         ir  <= Ins;
         pc4 <= nextPC;
         vld <= 1'b1;
      end
   end

   assign f    = split_ins(ir);
   assign kind = classify_br(f.op, f.funct);

   id_stage_reg_file #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
      .clk (CLK),
      .rst (RST),
      .we  (WB_WE),
      .wa  (WB_Rd),
      .wd  (WB_Data),
      .ra0 (f.rs),
      .ra1 (f.rt),
      .rd0 (rs_val),
      .rd1 (rt_val)
   );

   assign imm    = is_zext_op(f.op) ? {{(DATA_W-16){1'b0}}, ir[15:0]}
                                    : {{(DATA_W-16){ir[15]}}, ir[15:0]};
   assign br_off = {{(DATA_W-18){ir[15]}}, ir[15:0], 2'b00};

   // Hazards. Load-use compares both fields regardless of format; the
   // branch-operand check only covers registers the branch actually reads.
   assign load_use = EX_MemRd && (EX_Dst != '0) && ((EX_Dst == f.rs) || (EX_Dst == f.rt));

   always_comb begin
      br_src_hit = 1'b0;
      case (kind)
         BR_BEQ, BR_BNE: br_src_hit = (EX_Dst == f.rs) || (EX_Dst == f.rt);
         BR_JR:          br_src_hit = (EX_Dst == f.rs);
         default:        br_src_hit = 1'b0;
      endcase
   end

   assign br_hz = EX_RegWr && (EX_Dst != '0) && br_src_hit;
   assign stall = vld && (load_use || br_hz);

   always_comb begin
      cond   = 1'b0;
      target = pc4;
      case (kind)
         BR_BEQ:  begin cond = (rs_val == rt_val); target = pc4 + br_off; end
         BR_BNE:  begin cond = (rs_val != rt_val); target = pc4 + br_off; end
         BR_JUMP: begin cond = 1'b1; target = {pc4[DATA_W-1 -: 4], ir[25:0], 2'b00}; end
         BR_JR:   begin cond = 1'b1; target = rs_val; end
         default: begin cond = 1'b0; target = pc4; end
      endcase
   end

   // a stalled branch must not redirect: its operands are not final yet
   assign taken = vld && !stall && cond;

   // Everything is forced to zero while RST is high so the reset cycle
   // presents a clean bubble even though ir still holds the old instruction.
   always_comb begin
      Stall    = 1'b0;
      BrTaken  = 1'b0;
      BrTarget = '0;
      ID_Valid = 1'b0;
      Op       = '0;
      Funct    = '0;
      Rs       = '0;
      Rt       = '0;
      Rd       = '0;
      Shamt    = '0;
      Imm      = '0;
      RsVal    = '0;
      RtVal    = '0;
      PC4      = '0;
      if (!RST) begin
         Stall    = stall;
         BrTaken  = taken;
         BrTarget = taken ? target : pc4;
         ID_Valid = vld && !stall;
         Op       = f.op;
         Funct    = f.funct;
         Rs       = f.rs;
         Rt       = f.rt;
         Rd       = f.rd;
         Shamt    = f.shamt;
         Imm      = imm;
         RsVal    = rs_val;
         RtVal    = rt_val;
         PC4      = pc4;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] Ins, nextPC, WB_Data;
   logic        WB_WE, EX_MemRd, EX_RegWr;
   logic [4:0]  WB_Rd, EX_Dst;
   logic        Stall, BrTaken, ID_Valid;
   logic [31:0] BrTarget, Imm, RsVal, RtVal, PC4;
   logic [5:0]  Op, Funct;
   logic [4:0]  Rs, Rt, Rd, Shamt;

   id_stage dut (
      .CLK(CLK), .RST(RST), .Ins(Ins), .nextPC(nextPC),
      .WB_WE(WB_WE), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
      .EX_MemRd(EX_MemRd), .EX_RegWr(EX_RegWr), .EX_Dst(EX_Dst),
      .Stall(Stall), .BrTaken(BrTaken), .BrTarget(BrTarget), .ID_Valid(ID_Valid),
      .Op(Op), .Funct(Funct), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt),
      .Imm(Imm), .RsVal(RsVal), .RtVal(RtVal), .PC4(PC4)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   localparam int S_VLD = 0, S_STALL = 1, S_BRT = 2, S_TGT = 3,
                  S_RS = 4, S_RT = 5, S_IMM = 6, S_OP = 7, S_PC4 = 8;

   typedef struct {
      int          cyc;
      string       name;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] probe(input int sel);
      case (sel)
         S_VLD:   return 32'(ID_Valid);
         S_STALL: return 32'(Stall);
         S_BRT:   return 32'(BrTaken);
         S_TGT:   return BrTarget;
         S_RS:    return RsVal;
         S_RT:    return RtVal;
         S_IMM:   return Imm;
         S_OP:    return 32'(Op);
         S_PC4:   return PC4;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // expectation for the outputs of the current cycle
   task automatic expect_sig(input string name, input int sel, input logic [31:0] val);
      exp_t e;
      e.cyc  = cyc;
      e.name = name;
      e.sel  = sel;
      e.val  = val;
      sb.push_back(e);
   endtask

   // start a new cycle and drive all inputs for it
   task automatic drive(input logic rst, input logic [31:0] ins, input logic [31:0] npc,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wdat,
                        input logic mrd, input logic rwr, input logic [4:0] dst);
      @(posedge CLK);
      #1;
      RST = rst; Ins = ins; nextPC = npc;
      WB_WE = we; WB_Rd = wrd; WB_Data = wdat;
      EX_MemRd = mrd; EX_RegWr = rwr; EX_Dst = dst;
   endtask

   // monitor: compares whatever was expected for this cycle
   always @(negedge CLK) begin
      exp_t        e;
      logic [31:0] got;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_cmp++;
         if (e.cyc != cyc) begin
            n_bad++;
            $display("FAIL %s: expected in cycle %0d, not sampled (now %0d)", e.name, e.cyc, cyc);
         end else begin
            got = probe(e.sel);
            if (got !== e.val) begin
               n_bad++;
               $display("FAIL %s (cycle %0d): got 0x%08h want 0x%08h", e.name, cyc, got, e.val);
            end
         end
      end
   end

   initial begin
      RST = 1'b1; Ins = '0; nextPC = '0; WB_WE = 1'b0; WB_Rd = '0; WB_Data = '0;
      EX_MemRd = 1'b0; EX_RegWr = 1'b0; EX_Dst = '0;

      // 1: reset cycle
      drive(1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
      expect_sig("rst_vld",   S_VLD,   0);
      expect_sig("rst_stall", S_STALL, 0);
      expect_sig("rst_brt",   S_BRT,   0);
      expect_sig("rst_tgt",   S_TGT,   0);
      // 2: write r5, fetch add r1,r5,r0
      drive(0, rtype(5, 0, 1, 6'h20), 32'h4, 1, 5, 32'h1234, 0, 0, 0);
      expect_sig("post_rst_vld", S_VLD, 0);
      // 3: add decoded, write to r0 attempted
      drive(0, rtype(0, 5, 2, 6'h20), 32'h8, 1, 0, 32'hDEAD, 0, 0, 0);
      expect_sig("add_vld", S_VLD, 1);
      expect_sig("add_rs",  S_RS,  32'h1234);
      expect_sig("r0_zero", S_RT,  0);
      expect_sig("add_pc4", S_PC4, 32'h4);
      // 4: WB r5 in same cycle as ID reads r5 -> bypass
      drive(0, itype(6'h04, 1, 1, 16'd3), 32'h100, 1, 5, 32'h777, 0, 0, 0);
      expect_sig("r0_rs",  S_RS, 0);
      expect_sig("bypass", S_RT, 32'h777);
      // 5: beq r1,r1,+3
      drive(0, itype(6'h08, 0, 9, 16'd1), 32'h104, 0, 0, 0, 0, 0, 0);
      expect_sig("beq_vld", S_VLD, 1);
      expect_sig("beq_brt", S_BRT, 1);
      expect_sig("beq_tgt", S_TGT, 32'h10C);
      // 6: flushed slot
      drive(0, itype(6'h05, 1, 5, 16'hFFFF), 32'h200, 0, 0, 0, 0, 0, 0);
      expect_sig("flush_vld", S_VLD, 0);
      expect_sig("flush_brt", S_BRT, 0);
      expect_sig("flush_tgt", S_TGT, 32'h100);
      // 7: bne r1(0), r5(0x777), -1
      drive(0, 32'h0, 32'h204, 0, 0, 0, 0, 0, 0);
      expect_sig("bne_brt", S_BRT, 1);
      expect_sig("bne_tgt", S_TGT, 32'h1FC);
      // 8: flushed, fetch beq r0,r0,-1 at pc4=0
      drive(0, itype(6'h04, 0, 0, 16'hFFFF), 32'h0, 0, 0, 0, 0, 0, 0);
      expect_sig("flush2_vld", S_VLD, 0);
      // 9: target wraps below zero
      drive(0, 32'h0, 32'h4, 0, 0, 0, 0, 0, 0);
      expect_sig("wrap_brt", S_BRT, 1);
      expect_sig("wrap_tgt", S_TGT, 32'hFFFF_FFFC);
      // 10: load in EX while ID holds a bubble -> no stall
      drive(0, rtype(2, 4, 3, 6'h20), 32'h300, 0, 0, 0, 1, 0, 2);
      expect_sig("bubble_nostall", S_STALL, 0);
      // 11: load-use on add r3,r2,r4
      drive(0, itype(6'h0D, 0, 1, 16'h8000), 32'h304, 0, 0, 0, 1, 0, 2);
      expect_sig("lu_stall", S_STALL, 1);
      expect_sig("lu_vld",   S_VLD,   0);
      // 12: load gone, add reissues
      drive(0, itype(6'h0D, 0, 1, 16'h8000), 32'h304, 0, 0, 0, 0, 0, 0);
      expect_sig("reissue_stall", S_STALL, 0);
      expect_sig("reissue_vld",   S_VLD,   1);
      expect_sig("reissue_pc4",   S_PC4,   32'h300);
      // 13: ori -> zero-extended
      drive(0, itype(6'h08, 0, 1, 16'h8000), 32'h308, 0, 0, 0, 0, 0, 0);
      expect_sig("ori_imm", S_IMM, 32'h0000_8000);
      expect_sig("ori_op",  S_OP,  32'h0D);
      // 14: addi -> sign-extended; write r31
      drive(0, {6'h03, 26'h0400000}, 32'hA000_0010, 1, 31, 32'h40, 0, 0, 0);
      expect_sig("addi_imm", S_IMM, 32'hFFFF_8000);
      // 15: jal
      drive(0, 32'h0, 32'hA000_0014, 0, 0, 0, 0, 0, 0);
      expect_sig("jal_brt", S_BRT, 1);
      expect_sig("jal_tgt", S_TGT, 32'hA100_0000);
      // 16: flushed, fetch jr r31
      drive(0, rtype(31, 0, 0, 6'h08), 32'h50, 0, 0, 0, 0, 0, 0);
      expect_sig("flush3_vld", S_VLD, 0);
      // 17: jr with r31 being written by EX -> branch-operand stall
      drive(0, rtype(7, 8, 6, 6'h20), 32'h54, 0, 0, 0, 0, 1, 31);
      expect_sig("jr_hz_stall", S_STALL, 1);
      expect_sig("jr_hz_brt",   S_BRT,   0);
      expect_sig("jr_hz_vld",   S_VLD,   0);
      // 18: EX writes $0 -> no hazard, jr resolves
      drive(0, rtype(7, 8, 6, 6'h20), 32'h54, 0, 0, 0, 0, 1, 0);
      expect_sig("jr_stall", S_STALL, 0);
      expect_sig("jr_brt",   S_BRT,   1);
      expect_sig("jr_tgt",   S_TGT,   32'h40);
      // 19: flushed, fetch add r3,r2,r4
      drive(0, rtype(2, 4, 3, 6'h20), 32'h70, 0, 0, 0, 0, 0, 0);
      expect_sig("flush4_vld", S_VLD, 0);
      // 20: load-use on rt
      drive(0, rtype(5, 31, 1, 6'h20), 32'h4, 0, 0, 0, 1, 0, 4);
      expect_sig("lu_rt_stall", S_STALL, 1);
      // 21: reset during stall
      drive(1, rtype(5, 31, 1, 6'h20), 32'h4, 0, 0, 0, 1, 0, 4);
      expect_sig("rst_mid_stall", S_STALL, 0);
      expect_sig("rst_mid_vld",   S_VLD,   0);
      expect_sig("rst_mid_tgt",   S_TGT,   0);
      // 22: after reset
      drive(0, rtype(5, 31, 1, 6'h20), 32'h4, 0, 0, 0, 1, 0, 4);
      expect_sig("after_rst_stall", S_STALL, 0);
      expect_sig("after_rst_vld",   S_VLD,   0);
      // 23: registers cleared by reset
      drive(0, 32'h0, 32'h8, 0, 0, 0, 0, 0, 0);
      expect_sig("clr_vld", S_VLD, 1);
      expect_sig("clr_r5",  S_RS,  0);
      expect_sig("clr_r31", S_RT,  0);

      repeat (2) @(posedge CLK);
      #1;
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL %s: expectation never checked, got none want 0x%08h", e.name, e.val);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
